// File: rtl/mimo_input_packer.sv
// Packs a stream of Q6.10 samples into 128-bit channel/data beats for the MIMO detector input,
// with a single output holding register and a valid/ready handshake toward the detector.
module mimo_input_packer #(
    parameter int unsigned INT_W   = 6,
    parameter int unsigned FRAC_W  = 10,
    parameter int unsigned I_WIDTH = INT_W + FRAC_W,
    parameter int unsigned N_SMP   = 8,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [I_WIDTH-1:0]       s_data,
    input  logic                     s_flag,
    output logic                     o_in_valid,
    output logic                     o_flag,
    output logic [I_WIDTH*N_SMP-1:0] o_data,
    input  logic                     i_in_ready,
    output logic [CNT_W-1:0]         chan_beats,
    output logic [CNT_W-1:0]         data_beats,
    output logic                     err_flag_mismatch
);

    localparam int unsigned IDX_W = (N_SMP > 1) ? $clog2(N_SMP) : 1;
    localparam int unsigned ASM_W = I_WIDTH * (N_SMP - 1);

    logic [IDX_W-1:0]         cnt_q;
    logic [ASM_W-1:0]         asm_q;
    logic                     flag_q;
    logic                     valid_q;
    logic                     oflag_q;
    logic [I_WIDTH*N_SMP-1:0] odata_q;
    logic [CNT_W-1:0]         chan_q;
    logic [CNT_W-1:0]         data_q;
    logic                     err_q;

    logic last_smp;
    logic accept;
    logic xfer;

    always_comb begin
        last_smp = (cnt_q == IDX_W'(N_SMP - 1));
        // Combinational i_in_ready -> s_ready lets the final sample load while the old beat drains.
        s_ready  = !last_smp || !valid_q || i_in_ready;
        accept   = s_valid && s_ready;
        xfer     = valid_q && i_in_ready;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_q  <= '0;
            asm_q  <= '0;
            flag_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (accept) begin
            cnt_q <= last_smp ? '0 : cnt_q + IDX_W'(1);
            // Earliest sample shifts toward the MSBs so sample 0 ends up on top.
            asm_q <= {asm_q[ASM_W-I_WIDTH-1:0], s_data};
            if (cnt_q == '0) begin
                flag_q <= s_flag;
            end else if (s_flag != flag_q) begin
                err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            valid_q <= 1'b0;
            oflag_q <= 1'b0;
            odata_q <= '0;
        end else if (accept && last_smp) begin
            valid_q <= 1'b1;
            oflag_q <= flag_q;
            odata_q <= {asm_q, s_data};
        end else if (xfer) begin
            valid_q <= 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            chan_q <= '0;
            data_q <= '0;
        end else if (xfer) begin
            if (oflag_q) begin
                chan_q <= chan_q + CNT_W'(1);
            end else begin
                data_q <= data_q + CNT_W'(1);
            end
        end
    end

    assign o_in_valid        = valid_q;
    assign o_flag            = oflag_q;
    assign o_data            = odata_q;
    assign chan_beats        = chan_q;
    assign data_beats        = data_q;
    assign err_flag_mismatch = err_q;

endmodule
